// File: rtl/lsu_pkg.sv
// Shared types and RV32I width codes for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } lsu_state_e;

    // Funct3 width codes (loads and stores share B/H/W encodings)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // A request is rejected without touching RAM when its width code is not
    // legal for its direction, or its address is not naturally aligned.
    function automatic logic req_illegal(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        if (is_store)
            bad = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            bad = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        case (funct3)
            F3_H, F3_HU: if (addr_lo[0]) bad = 1'b1;
            F3_W:        if (addr_lo != 2'b00) bad = 1'b1;
            default:     ;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and RAM-side bus of the load/store unit.
interface load_store_unit_if #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32
);
    // core side
    logic                   Start;
    logic                   IsStore;
    logic [2:0]             Funct3;
    logic [RAMAddrSize-1:0] Addr;
    logic [dataW-1:0]       StoreData;
    logic                   Busy;
    logic                   Done;
    logic                   Error;
    logic [dataW-1:0]       LoadData;
    // RAM side
    logic [RAMAddrSize-1:0] RAMAddr;
    logic [dataW-1:0]       RAMDataOut;
    logic                   RAMWriteControl;
    logic [dataW-1:0]       RAMIn;

    // the load/store unit itself
    modport slave (
        input  Start, IsStore, Funct3, Addr, StoreData, RAMIn,
        output Busy, Done, Error, LoadData, RAMAddr, RAMDataOut, RAMWriteControl
    );

    // the environment: core plus RAM
    modport master (
        output Start, IsStore, Funct3, Addr, StoreData, RAMIn,
        input  Busy, Done, Error, LoadData, RAMAddr, RAMDataOut, RAMWriteControl
    );
endinterface

// File: rtl/lsu_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int dataW = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    input  logic [dataW-1:0] rdata,
    input  logic [dataW-1:0] wdata,
    output logic [dataW-1:0] load_val,
    output logic [dataW-1:0] merged
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // byte lane k lives at bits [8k+7:8k]; half lane chosen by addr_lo[1]
    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

    // extend the selected lane to a full word
    always_comb begin
        load_val = rdata;
        case (funct3)
            F3_B:    load_val = {{(dataW-8){byte_lane[7]}}, byte_lane};
            F3_BU:   load_val = {{(dataW-8){1'b0}}, byte_lane};
            F3_H:    load_val = {{(dataW-16){half_lane[15]}}, half_lane};
            F3_HU:   load_val = {{(dataW-16){1'b0}}, half_lane};
            default: load_val = rdata;
        endcase
    end

    // overwrite only the addressed lane; the rest stays as read
    always_comb begin
        merged = rdata;
        case (funct3)
            F3_B:    merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores against a word-wide RAM,
// sub-word stores done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.slave   lsu
);
    lsu_state_e             state;
    logic                   is_store_q;
    logic [2:0]             funct3_q;
    logic [1:0]             addr_lo_q;
    logic [dataW-1:0]       store_data_q;

    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic                   we_q;
    logic [dataW-1:0]       load_data_q;
    logic [dataW-1:0]       wdata_q;
    logic [RAMAddrSize-1:0] ram_addr_q;

    logic                   req_bad;
    logic [RAMAddrSize-1:0] word_addr_in;
    logic [dataW-1:0]       load_val;
    logic [dataW-1:0]       merged;

    assign req_bad      = req_illegal(lsu.IsStore, lsu.Funct3, lsu.Addr[1:0]);
    assign word_addr_in = {lsu.Addr[RAMAddrSize-1:2], 2'b00};

    lsu_align #(.dataW(dataW)) u_align (
        .funct3   (funct3_q),
        .addr_lo  (addr_lo_q),
        .rdata    (lsu.RAMIn),
        .wdata    (store_data_q),
        .load_val (load_val),
        .merged   (merged)
    );

    // request sequencer; every output is a register updated with the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            store_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            we_q         <= 1'b0;
            load_data_q  <= '0;
            wdata_q      <= '0;
            ram_addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu.Start) begin
                        is_store_q   <= lsu.IsStore;
                        funct3_q     <= lsu.Funct3;
                        addr_lo_q    <= lsu.Addr[1:0];
                        store_data_q <= lsu.StoreData;
                        busy_q       <= 1'b1;
                        if (req_bad) begin
                            // reject straight away, RAM never addressed
                            state   <= DONE;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else if (!lsu.IsStore || lsu.Funct3 != F3_W) begin
                            // loads and sub-word stores both read first
                            state      <= READ;
                            ram_addr_q <= word_addr_in;
                        end else begin
                            // full-word store needs no read
                            state      <= WRITE;
                            ram_addr_q <= word_addr_in;
                            wdata_q    <= lsu.StoreData;
                            we_q       <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (is_store_q) begin
                        state   <= WRITE;
                        wdata_q <= merged;
                        we_q    <= 1'b1;
                    end else begin
                        state       <= DONE;
                        load_data_q <= load_val;
                        ram_addr_q  <= '0;
                        done_q      <= 1'b1;
                    end
                end
                WRITE: begin
                    state      <= DONE;
                    we_q       <= 1'b0;
                    ram_addr_q <= '0;
                    done_q     <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lsu.Busy            = busy_q;
    assign lsu.Done            = done_q;
    assign lsu.Error           = error_q;
    assign lsu.LoadData        = load_data_q;
    assign lsu.RAMAddr         = ram_addr_q;
    assign lsu.RAMDataOut      = wdata_q;
    assign lsu.RAMWriteControl = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests, a transaction
// level reference model checked every cycle, and literal expectations.
module tb_load_store_unit;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    load_store_unit_if #(.dataW(DW), .RAMAddrSize(AW)) bus ();

    load_store_unit #(.dataW(DW), .RAMAddrSize(AW)) dut (
        .clock (clock),
        .reset (reset),
        .lsu   (bus)
    );

    int checks = 0;
    int errors = 0;

    // RAM behind the DUT, plus a preload port for the bench
    logic [31:0] ram     [0:63] = '{default: '0};
    logic [31:0] ref_mem [0:63] = '{default: '0};
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    assign bus.RAMIn = ram[bus.RAMAddr[7:2]];

    always @(posedge clock) begin
        if (bus.RAMWriteControl) ram[bus.RAMAddr[7:2]] <= bus.RAMDataOut;
        else if (pre_we)         ram[pre_idx] <= pre_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // ---- reference model: plain arithmetic on widths and byte offsets ----
    function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        if (f3[1:0] == 2'b11) return 1'b1;
        if (st && f3[2])      return 1'b1;
        if (f3 == 3'b110)     return 1'b1;
        nb = 1 << f3[1:0];
        if (int'(a[1:0]) % nb != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int     nb;
        int     sh;
        longint v;
        nb = 1 << f3[1:0];
        sh = 8 * int'(a[1:0]);
        if (nb == 4) return w;
        v = longint'(w >> sh) & ((longint'(1) << (8 * nb)) - 1);
        if (!f3[2] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] w, input logic [31:0] d);
        int     nb;
        int     sh;
        longint mask;
        nb = 1 << f3[1:0];
        sh = 8 * int'(a[1:0]);
        if (nb == 4) return d;
        mask = ((longint'(1) << (8 * nb)) - 1) << sh;
        return 32'((longint'(w) & ~mask) | ((longint'(d) << sh) & mask));
    endfunction

    // ---- per-cycle compare against the model ----
    logic        m_busy = 1'b0;
    logic        m_err, m_st;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata, m_ld;
    logic [31:0] exp_ld = '0;
    int          k, done_k, we_k;

    always @(posedge clock) begin
        #1;
        if (reset) begin
            m_busy = 1'b0;
            exp_ld = '0;
            if (pre_we) ref_mem[pre_idx] = pre_data;
            chk_b("rst_busy", bus.Busy, 1'b0);
            chk_b("rst_done", bus.Done, 1'b0);
            chk_b("rst_error", bus.Error, 1'b0);
            chk_b("rst_we", bus.RAMWriteControl, 1'b0);
            chk("rst_ramaddr", bus.RAMAddr, 32'h0);
            chk("rst_loaddata", bus.LoadData, 32'h0);
        end else begin
            if (m_busy) begin
                k++;
                if (k > done_k) m_busy = 1'b0;
            end else if (bus.Start) begin
                m_st   = bus.IsStore;
                m_f3   = bus.Funct3;
                m_addr = bus.Addr;
                m_err  = model_err(m_st, m_f3, m_addr);
                k      = 0;
                m_busy = 1'b1;
                done_k = 1;
                we_k   = -1;
                if (m_err) done_k = 0;
                else if (!m_st) m_ld = model_load(m_f3, m_addr, ref_mem[m_addr[7:2]]);
                else if (m_f3 == 3'b010) begin
                    we_k    = 0;
                    m_wdata = bus.StoreData;
                end else begin
                    done_k  = 2;
                    we_k    = 1;
                    m_wdata = model_store(m_f3, m_addr, ref_mem[m_addr[7:2]], bus.StoreData);
                end
            end
            if (m_busy) begin
                if (k == done_k && !m_err) begin
                    if (m_st) ref_mem[m_addr[7:2]] = m_wdata;
                    else      exp_ld = m_ld;
                end
                chk_b("cyc_busy", bus.Busy, 1'b1);
                chk_b("cyc_done", bus.Done, k == done_k);
                chk_b("cyc_error", bus.Error, k == done_k && m_err);
                chk_b("cyc_we", bus.RAMWriteControl, k == we_k);
                chk("cyc_ramaddr", bus.RAMAddr,
                    (!m_err && k < done_k) ? {m_addr[31:2], 2'b00} : 32'h0);
                if (k == we_k) chk("cyc_wdata", bus.RAMDataOut, m_wdata);
                chk("cyc_loaddata", bus.LoadData, exp_ld);
            end else begin
                chk_b("idle_busy", bus.Busy, 1'b0);
                chk_b("idle_done", bus.Done, 1'b0);
                chk_b("idle_error", bus.Error, 1'b0);
                chk_b("idle_we", bus.RAMWriteControl, 1'b0);
                chk("idle_ramaddr", bus.RAMAddr, 32'h0);
                chk("idle_loaddata", bus.LoadData, exp_ld);
            end
        end
    end

    // ---- stimulus ----
    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = d;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after
    // the Done cycle so the next call is back-to-back.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic poke, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_load, input string nm);
        int n;
        bus.Start     = 1'b1;
        bus.IsStore   = st;
        bus.Funct3    = f3;
        bus.Addr      = a;
        bus.StoreData = d;
        @(negedge clock);
        if (poke) begin
            // a competing store held on Start while busy must be ignored
            bus.IsStore   = 1'b1;
            bus.Funct3    = 3'b010;
            bus.Addr      = 32'h44;
            bus.StoreData = 32'hBAD0BAD0;
        end else begin
            bus.Start     = 1'b0;
            bus.IsStore   = 1'($urandom);
            bus.Funct3    = 3'($urandom);
            bus.Addr      = $urandom;
            bus.StoreData = $urandom;
        end
        n = 1;
        while (bus.Done !== 1'b1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        bus.Start = 1'b0;
        chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
        chk_b({nm, "_err"}, bus.Error, exp_err);
        chk({nm, "_ld"}, bus.LoadData, exp_load);
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b1;
        bus.Start     = 1'b0;
        bus.IsStore   = 1'b0;
        bus.Funct3    = 3'b000;
        bus.Addr      = 32'h0;
        bus.StoreData = 32'h0;
        pre_we        = 1'b0;
        pre_idx       = '0;
        pre_data      = '0;
        repeat (2) @(negedge clock);
        chk_b("lit_rst_busy", bus.Busy, 1'b0);
        chk("lit_rst_ld", bus.LoadData, 32'h0);
        chk("lit_rst_dout", bus.RAMDataOut, 32'h0);
        preload(6'h04, 32'h8899AABB);
        preload(6'h08, 32'h11223344);
        preload(6'h0C, 32'hCAFEF00D);
        reset = 1'b0;
        @(negedge clock);

        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 2, 1'b0, 32'h8899AABB, "lw_10");
        issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 2, 1'b0, 32'hFFFFFF88, "lb_13");
        issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 2, 1'b0, 32'h00000088, "lbu_13");
        issue(1'b1, 3'b000, 32'h21, 32'h000000CC, 1'b0, 3, 1'b0, 32'h00000088, "sb_21");
        chk("sb_21_ram", ram[8], 32'h1122CC44);
        issue(1'b1, 3'b010, 32'h0A, 32'h12345678, 1'b0, 1, 1'b1, 32'h00000088, "sw_0a_mis");
        issue(1'b0, 3'b001, 32'h0B, 32'h0, 1'b0, 1, 1'b1, 32'h00000088, "lh_0b_mis");
        issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, 1, 1'b1, 32'h00000088, "ld_f3_011");
        issue(1'b1, 3'b100, 32'h20, 32'h0, 1'b0, 1, 1'b1, 32'h00000088, "st_f3_100");
        issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 2, 1'b0, 32'hFFFF8899, "lh_12");
        issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 2, 1'b0, 32'h0000AABB, "lhu_10");
        issue(1'b1, 3'b001, 32'h22, 32'hABCD5566, 1'b0, 3, 1'b0, 32'h0000AABB, "sh_22");
        chk("sh_22_ram", ram[8], 32'h5566CC44);

        // reset while a word store sits in WRITE
        bus.Start     = 1'b1;
        bus.IsStore   = 1'b1;
        bus.Funct3    = 3'b010;
        bus.Addr      = 32'h30;
        bus.StoreData = 32'hDEADBEEF;
        @(negedge clock);
        bus.Start = 1'b0;
        chk_b("abort_we_before", bus.RAMWriteControl, 1'b1);
        reset = 1'b1;
        #1;
        chk_b("abort_we", bus.RAMWriteControl, 1'b0);
        chk_b("abort_busy", bus.Busy, 1'b0);
        chk("abort_ramaddr", bus.RAMAddr, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_ram", ram[12], 32'hCAFEF00D);
        chk_b("abort_idle", bus.Busy, 1'b0);
        @(negedge clock);

        // back-to-back with an ignored Start while busy
        issue(1'b1, 3'b010, 32'h40, 32'h01020304, 1'b1, 2, 1'b0, 32'h0, "sw_40");
        issue(1'b0, 3'b101, 32'h42, 32'h0, 1'b0, 2, 1'b0, 32'h00000102, "lhu_42");
        issue(1'b0, 3'b010, 32'h44, 32'h0, 1'b0, 2, 1'b0, 32'h00000000, "lw_44_untouched");
        repeat (2) @(negedge clock);

        for (int i = 0; i < 64; i++) chk($sformatf("mem_%0d", i), ram[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
